shiftreg_univ: RTL

//  Parametrised universal shift register; next generation of the 4-bit load/shift-left/shift-right register.

---
 rtl/shiftreg_pkg.sv | 21 ++
 rtl/shiftreg_barrel.sv | 53 +++++
 rtl/shiftreg_univ.sv | 92 +++++++++
 3 files changed

// File: rtl/shiftreg_pkg.sv
// Shared types for the universal shift register: operation codes and serialiser states.
package shiftreg_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_SHL  = 3'b001,
        OP_SHR  = 3'b010,
        OP_LOAD = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_ASR  = 3'b110,
        OP_SER  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } ser_state_e;

endpackage

// File: rtl/shiftreg_barrel.sv
// Combinational next-value for the parallel ops (hold, load, shifts, rotates, arithmetic shift).
module shiftreg_barrel
    import shiftreg_pkg::*;
#(
    parameter  int N       = 8,
    localparam int SHAMT_W = $clog2(N)
) (
    input  logic [N-1:0]       q_i,
    input  logic [N-1:0]       d_i,
    input  logic [2:0]         op_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               fill_left_i,
    input  logic               fill_right_i,
    output logic [N-1:0]       q_next_o
);

    int unsigned amt;
    int unsigned rot;

    always_comb begin
        q_next_o = q_i;
        amt      = 32'(shamt_i);
        // Rotates wrap; plain shifts saturate to all-fill once amt reaches N.
        rot      = amt % N;
        unique case (op_e'(op_i))
            OP_HOLD: q_next_o = q_i;
            OP_LOAD,
            OP_SER:  q_next_o = d_i;
            OP_SHL: begin
                for (int i = 0; i < N; i++)
                    q_next_o[i] = (i >= amt) ? q_i[i - amt] : fill_left_i;
            end
            OP_SHR: begin
                for (int i = 0; i < N; i++)
                    q_next_o[i] = (i + amt < N) ? q_i[i + amt] : fill_right_i;
            end
            OP_ASR: begin
                for (int i = 0; i < N; i++)
                    q_next_o[i] = (i + amt < N) ? q_i[i + amt] : q_i[N-1];
            end
            OP_ROL: begin
                for (int i = 0; i < N; i++)
                    q_next_o[i] = q_i[(i + N - rot) % N];
            end
            OP_ROR: begin
                for (int i = 0; i < N; i++)
                    q_next_o[i] = q_i[(i + rot) % N];
            end
            default: q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/shiftreg_univ.sv
// Universal shift register with a self-timed LSB-first serialiser (IDLE -> SHIFT -> DONE).
module shiftreg_univ
    import shiftreg_pkg::*;
#(
    parameter  int N       = 8,
    localparam int SHAMT_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [2:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               shift_in_left,
    input  logic               shift_in_right,
    input  logic [N-1:0]       d,
    output logic [N-1:0]       q,
    output logic               shift_out_left,
    output logic               shift_out_right,
    output logic               ser_out,
    output logic               ser_busy,
    output logic               ser_done,
    output ser_state_e         dbg_state
);

    localparam int CNT_W = SHAMT_W;

    logic [N-1:0]     q_q, q_d;
    logic [N-1:0]     barrel_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ser_state_e       state_q, state_d;

    shiftreg_barrel #(.N(N)) u_barrel (
        .q_i          (q_q),
        .d_i          (d),
        .op_i         (op),
        .shamt_i      (shamt),
        .fill_left_i  (shift_in_left),
        .fill_right_i (shift_in_right),
        .q_next_o     (barrel_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q     <= '0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
        end else begin
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        q_d     = q_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (en) begin
            unique case (state_q)
                S_SHIFT: begin
                    q_d = {shift_in_right, q_q[N-1:1]};
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                // DONE behaves like IDLE for the op presented on its single cycle.
                S_IDLE, S_DONE: begin
                    if (op_e'(op) == OP_SER) begin
                        q_d     = d;
                        cnt_d   = CNT_W'(N - 1);
                        state_d = S_SHIFT;
                    end else begin
                        q_d     = barrel_q;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign q               = q_q;
    assign shift_out_left  = q_q[N-1];
    assign shift_out_right = q_q[0];
    assign ser_busy        = (state_q == S_SHIFT);
    assign ser_done        = (state_q == S_DONE);
    assign ser_out         = ser_busy & q_q[0];
    assign dbg_state       = state_q;

endmodule
